// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one register stage per slice of 4-bit CLA groups.
// Define CLA_OVF_EN to add the registered signed-overflow output 'ovf'.
module cla_pipe_adder #(
    parameter int WIDTH            = 32,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SW      = 4 * GROUPS_PER_STAGE;
    localparam int NSTAGES = WIDTH / SW;

    // One slice of chained 4-bit lookahead groups; returns {carry_out, sum}.
    function automatic logic [SW:0] add_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [SW:0]   c;
        logic [3:0]    gp;
        logic [3:0]    gg;
        logic          cg;
        logic          grp_g;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
            gp = p[4*j +: 4];
            gg = g[4*j +: 4];
            cg = c[4*j];
            c[4*j+1] = gg[0] | (gp[0] & cg);
            c[4*j+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cg);
            c[4*j+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                     | (gp[2] & gp[1] & gp[0] & cg);
            grp_g    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                     | (gp[3] & gp[2] & gp[1] & gg[0]);
            c[4*j+4] = grp_g | ((&gp) & cg);
        end
        return {c[SW], p ^ c[SW-1:0]};
    endfunction

    logic [WIDTH-1:0]   b_e;
    logic               c_e;
    logic [NSTAGES-1:0] valid;
    logic [NSTAGES:0]   ready;

    assign b_e = b ^ {WIDTH{sub}};
    assign c_e = c_in ^ sub;

    // A stage can take new data when empty or when its occupant moves on this cycle.
    always_comb begin
        ready          = '0;
        ready[NSTAGES] = out_ready;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            ready[k] = ~valid[k] | ready[k+1];
        end
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : stg
        localparam int IW = WIDTH - k * SW;

        logic                src_valid;
        logic                src_c;
        logic [IW-1:0]       src_a;
        logic [IW-1:0]       src_b;
        logic [(k+1)*SW-1:0] sum_next;
        logic [(k+1)*SW-1:0] sum_r;
        logic [SW-1:0]       s;
        logic                co;
        logic                c_r;

        if (k == 0) begin : g_src
            assign src_valid = in_valid;
            assign src_a     = a;
            assign src_b     = b_e;
            assign src_c     = c_e;
            assign sum_next  = s;
        end else begin : g_src
            assign src_valid = valid[k-1];
            assign src_a     = stg[k-1].g_ops.op_a_r;
            assign src_b     = stg[k-1].g_ops.op_b_r;
            assign src_c     = stg[k-1].c_r;
            assign sum_next  = {s, stg[k-1].sum_r};
        end

        assign {co, s} = add_slice(src_a[SW-1:0], src_b[SW-1:0], src_c);

        always_ff @(posedge clk) begin
            if (rst) begin
                valid[k] <= 1'b0;
            end else if (ready[k]) begin
                valid[k] <= src_valid;
            end
        end

        // Data only moves with a real transaction so idle stages stay quiet.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_r <= '0;
                c_r   <= 1'b0;
            end else if (ready[k] && src_valid) begin
                sum_r <= sum_next;
                c_r   <= co;
            end
        end

        if (k < NSTAGES - 1) begin : g_ops
            logic [IW-SW-1:0] op_a_r;
            logic [IW-SW-1:0] op_b_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    op_a_r <= '0;
                    op_b_r <= '0;
                end else if (ready[k] && src_valid) begin
                    op_a_r <= src_a[IW-1:SW];
                    op_b_r <= src_b[IW-1:SW];
                end
            end
        end
    end

    assign in_ready  = ready[0] & ~rst;
    assign out_valid = valid[NSTAGES-1];
    assign sum       = stg[NSTAGES-1].sum_r;
    assign c_out     = stg[NSTAGES-1].c_r;

`ifdef CLA_OVF_EN
    logic ovf_r;

    // Carry into the MSB is recovered as a ^ b ^ sum at the top bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (ready[NSTAGES-1] && stg[NSTAGES-1].src_valid) begin
            ovf_r <= stg[NSTAGES-1].co ^ (stg[NSTAGES-1].src_a[SW-1]
                                        ^ stg[NSTAGES-1].src_b[SW-1]
                                        ^ stg[NSTAGES-1].s[SW-1]);
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=32, GROUPS_PER_STAGE=2, four stages):
// directed vector table plus multi-cycle burst, stall and reset-flush sequences.
module tb_cla_pipe_adder;

    localparam int WIDTH   = 32;
    localparam int NSTAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef CLA_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    cla_pipe_adder #(
        .WIDTH            (WIDTH),
        .GROUPS_PER_STAGE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef CLA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c_in;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc_cyc;
    } vec_t;

    vec_t pend_q[$];
    vec_t exp_q[$];
    vec_t tbl[12];

    int checks    = 0;
    int passes    = 0;
    int cyc       = 0;
    bit check_lat = 1'b0;
    int first_acc, last_acc, first_out, last_out;

    function automatic vec_t mkvec(input logic [31:0] va, input logic [31:0] vb,
                                   input logic vc, input logic vs,
                                   input logic [31:0] esum, input logic ecout, input logic eovf);
        vec_t v;
        v.a = va; v.b = vb; v.c_in = vc; v.sub = vs;
        v.sum = esum; v.cout = ecout; v.ovf = eovf; v.acc_cyc = 0;
        return v;
    endfunction

    // Reference: plain wide addition, overflow from operand/result signs.
    function automatic vec_t model(input logic [31:0] va, input logic [31:0] vb,
                                   input logic vc, input logic vs);
        vec_t        v;
        logic [31:0] be;
        logic [32:0] full;
        be   = vs ? ~vb : vb;
        full = {1'b0, va} + {1'b0, be} + {32'd0, vc ^ vs};
        v    = mkvec(va, vb, vc, vs, full[31:0], full[32],
                     (va[31] == be[31]) && (full[31] != va[31]));
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: present the next pending op, score any output transfer and any input accept.
    task automatic apply_stimulus(input logic ordy);
        vec_t e;
        vec_t v;
        @(posedge clk);
        #1;
        cyc++;
        if (pend_q.size() > 0) begin
            in_valid = 1'b1;
            a        = pend_q[0].a;
            b        = pend_q[0].b;
            c_in     = pend_q[0].c_in;
            sub      = pend_q[0].sub;
        end else begin
            in_valid = 1'b0;
        end
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            check_output("result_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("sum", 64'(sum), 64'(e.sum));
                check_output("c_out", 64'(c_out), 64'(e.cout));
`ifdef CLA_OVF_EN
                check_output("ovf", 64'(ovf), 64'(e.ovf));
`endif
                if (check_lat) check_output("latency", 64'(cyc - e.acc_cyc), 64'(NSTAGES));
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
        end
        if (in_valid && in_ready) begin
            v         = pend_q.pop_front();
            v.acc_cyc = cyc;
            exp_q.push_back(v);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (pend_q.size() > 0 || exp_q.size() > 0); i++) begin
            apply_stimulus(1'b1);
        end
        check_output("drain_done", 64'(pend_q.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0]  = mkvec(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        tbl[1]  = mkvec(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        tbl[2]  = mkvec(32'h00000005, 32'h00000003, 1'b1, 1'b0, 32'h00000009, 1'b0, 1'b0);
        tbl[3]  = mkvec(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        tbl[4]  = mkvec(32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        tbl[5]  = mkvec(32'h00000010, 32'h00000004, 1'b1, 1'b1, 32'h0000000B, 1'b1, 1'b0);
        tbl[6]  = mkvec(32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0);
        tbl[7]  = mkvec(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
        tbl[8]  = mkvec(32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0);
        tbl[9]  = mkvec(32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        tbl[10] = mkvec(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
        tbl[11] = mkvec(32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
        first_acc = -1; last_acc = -1; first_out = -1; last_out = -1;

        repeat (2) @(posedge clk);
        #1;
        check_output("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_sum", 64'(sum), 64'd0);
        check_output("reset_c_out", 64'(c_out), 64'd0);
`ifdef CLA_OVF_EN
        check_output("reset_ovf", 64'(ovf), 64'd0);
`endif
        check_output("in_ready_after_reset", 64'(in_ready), 64'd1);

        $display("[TB] directed vector table");
        check_lat = 1'b1;
        for (int i = 0; i < 12; i++) pend_q.push_back(tbl[i]);
        drain();
        check_lat = 1'b0;

        $display("[TB] back-to-back burst of 16");
        first_acc = -1; first_out = -1;
        for (int i = 0; i < 16; i++) begin
            pend_q.push_back(model($urandom, $urandom, 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1))));
        end
        drain();
        check_output("burst_accept_span", 64'(last_acc - first_acc), 64'd15);
        check_output("burst_output_span", 64'(last_out - first_out), 64'd15);

        $display("[TB] output stall with full pipe");
        for (int i = 0; i < 6; i++) begin
            pend_q.push_back(model(32'h01010101 * (i + 1), 32'h00FF00FF + i, 1'(i), 1'(i >> 1)));
        end
        for (int i = 1; i <= 7; i++) begin
            apply_stimulus(1'b0);
            if (i >= 5) begin
                check_output("stall_in_ready", 64'(in_ready), 64'd0);
                check_output("stall_out_valid", 64'(out_valid), 64'd1);
                check_output("stall_has_head", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check_output("stall_sum_held", 64'(sum), 64'(exp_q[0].sum));
                    check_output("stall_c_out_held", 64'(c_out), 64'(exp_q[0].cout));
                end
            end
        end
        check_output("stall_accepts", 64'(exp_q.size()), 64'd4);
        drain();

        $display("[TB] reset with ops in flight");
        for (int i = 0; i < 3; i++) pend_q.push_back(model(32'hA5A5A5A5, 32'(i), 1'b0, 1'b0));
        repeat (3) apply_stimulus(1'b1);
        check_output("flight_count", 64'(exp_q.size()), 64'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        check_output("flush_out_valid", 64'(out_valid), 64'd0);
        check_output("flush_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        #1;
        check_output("flush_in_ready_release", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1);
            check_output("flushed_no_output", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
